// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: registered 10b -> 8b data / 2b control decode plus bitslip word alignment.
// Defining TMDS_DEC_ERRCNT_EN adds the errCount port counting short control-token runs while locked.
module tmds_channel_decoder #(
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOSS_WINDOW   = 4096
) (
    input  logic        pixelClk,
    input  logic        resetn,
    input  logic [9:0]  tmdsIn,
    output logic [7:0]  dataOut,
    output logic        de,
    output logic [1:0]  ctrl,
    output logic        locked,
    output logic        bitslip
`ifdef TMDS_DEC_ERRCNT_EN
    ,
    output logic [15:0] errCount
`endif
);

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOSS_W = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_RUN);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic       is_token;
    logic [1:0] tok_ctrl;
    logic [7:0] q_inv;
    logic [7:0] dec_data;

    always_comb begin
        is_token = 1'b1;
        tok_ctrl = 2'b00;
        case (tmdsIn)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    // q[9] flags a DC-balancing inversion; q[8] selects XOR versus XNOR chaining.
    assign q_inv       = tmdsIn[9] ? ~tmdsIn[7:0] : tmdsIn[7:0];
    assign dec_data[0] = q_inv[0];

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_dec
            assign dec_data[gi] = tmdsIn[8] ? (q_inv[gi] ^ q_inv[gi-1])
                                            : ~(q_inv[gi] ^ q_inv[gi-1]);
        end
    endgenerate

    logic [7:0] data_reg;
    logic       de_reg;
    logic [1:0] ctrl_reg;

    always_ff @(posedge pixelClk or negedge resetn) begin
        if (!resetn) begin
            data_reg <= '0;
            de_reg   <= 1'b0;
            ctrl_reg <= 2'b00;
        end else begin
            de_reg <= ~is_token;
            if (is_token) ctrl_reg <= tok_ctrl;
            else          data_reg <= dec_data;
        end
    end

    assign dataOut = data_reg;
    assign de      = de_reg;
    assign ctrl    = ctrl_reg;

    logic [1:0]        state_reg,   state_next;
    logic [RUN_W-1:0]  run_reg,     run_next, run_step;
    logic [WIN_W-1:0]  window_reg,  window_next;
    logic [SET_W-1:0]  settle_reg,  settle_next;
    logic [LOSS_W-1:0] loss_reg,    loss_next;
    logic              bitslip_reg, bitslip_next;

    always_comb begin
        state_next   = state_reg;
        run_next     = run_reg;
        window_next  = window_reg;
        settle_next  = settle_reg;
        loss_next    = loss_reg;
        bitslip_next = (state_reg == ST_SLIP);
        run_step     = is_token ? ((run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1) : '0;
        case (state_reg)
            ST_SEARCH: begin
                run_next = run_step;
                // A completed token run takes priority over an expiring search window.
                if (run_reg == RUN_MAX) begin
                    state_next  = ST_LOCKED;
                    window_next = '0;
                    loss_next   = '0;
                end else if (window_reg == WIN_LAST) begin
                    state_next  = ST_SLIP;
                    run_next    = '0;
                    window_next = '0;
                end else begin
                    window_next = window_reg + 1'b1;
                end
            end
            ST_SLIP: begin
                state_next  = ST_SETTLE;
                settle_next = '0;
            end
            ST_SETTLE: begin
                if (settle_reg == SET_LAST) begin
                    state_next  = ST_SEARCH;
                    settle_next = '0;
                    run_next    = '0;
                    window_next = '0;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            ST_LOCKED: begin
                run_next = run_step;
                if (is_token) begin
                    loss_next = '0;
                end else if (loss_reg == LOSS_LAST) begin
                    state_next  = ST_SEARCH;
                    run_next    = '0;
                    window_next = '0;
                    loss_next   = '0;
                end else begin
                    loss_next = loss_reg + 1'b1;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge pixelClk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_SEARCH;
            run_reg     <= '0;
            window_reg  <= '0;
            settle_reg  <= '0;
            loss_reg    <= '0;
            bitslip_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            run_reg     <= run_next;
            window_reg  <= window_next;
            settle_reg  <= settle_next;
            loss_reg    <= loss_next;
            bitslip_reg <= bitslip_next;
        end
    end

    assign locked  = (state_reg == ST_LOCKED);
    assign bitslip = bitslip_reg;

`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_reg, err_next;

    // A run that ended before reaching LOCK_RUN tokens is a short (erroneous) control period.
    always_comb begin
        err_next = err_reg;
        if (state_reg == ST_LOCKED && !is_token && run_reg != '0 &&
            run_reg != RUN_MAX && err_reg != 16'hFFFF)
            err_next = err_reg + 16'd1;
    end

    always_ff @(posedge pixelClk or negedge resetn) begin
        if (!resetn) err_reg <= '0;
        else         err_reg <= err_next;
    end

    assign errCount = err_reg;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: a transmit-side TMDS encoder supplies data words,
// and a rotating-word deserializer model answers bitslip requests.
module tb_tmds_channel_decoder;

    localparam int LOCK_RUN = 8;
    localparam int SW       = 4096;
    localparam int SETTLE   = 16;
    localparam int LW       = 4096;

    logic       pixelClk = 1'b0;
    logic       resetn;
    logic [9:0] tmdsIn;
    logic [7:0] dataOut;
    logic       de;
    logic [1:0] ctrl;
    logic       locked;
    logic       bitslip;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] errCount;
`endif

    tmds_channel_decoder dut (
        .pixelClk (pixelClk),
        .resetn   (resetn),
        .tmdsIn   (tmdsIn),
        .dataOut  (dataOut),
        .de       (de),
        .ctrl     (ctrl),
        .locked   (locked),
        .bitslip  (bitslip)
`ifdef TMDS_DEC_ERRCNT_EN
        ,
        .errCount (errCount)
`endif
    );

    always #5 pixelClk = ~pixelClk;

    logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic bit is_token(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == tokens[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Transmit-side encoding: chain the byte with XOR or XNOR, then optionally invert the low byte.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d, input bit use_xnor, input bit inv);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        return {inv, ~use_xnor, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] t, input int o);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = t[(i + o) % 10];
        return r;
    endfunction

    task automatic rand_word(output logic [9:0] w, output logic [7:0] b);
        do begin
            b = 8'($urandom);
            w = tmds_encode(b, 1'($urandom), 1'($urandom));
        end while (is_token(w));
    endtask

    // Present one word, let the active edge take it, observe on the following negedge.
    task automatic step(input logic [9:0] w);
        tmdsIn = w;
        @(posedge pixelClk);
        @(negedge pixelClk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tmdsIn = '0;
        repeat (2) @(negedge pixelClk);
        resetn = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, dataOut, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_ctrl"}, ctrl, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_bitslip"}, bitslip, 0);
`ifdef TMDS_DEC_ERRCNT_EN
        check({tag, "_errcnt"}, errCount, 0);
`endif
    endtask

    logic [9:0] w;
    logic [7:0] b;
    logic [1:0] exp_ctrl;
    logic [1:0] kk;
    int         seen, found, offset, n_slip, last_slip, min_gap, cyc, got_lock;

    initial begin
        resetn = 1'b0;
        tmdsIn = '0;
        repeat (2) @(negedge pixelClk);
        check_reset_values("reset");
        resetn = 1'b1;

        // Aligned lock: eight 00 tokens then data 0x1F5, which decodes to 0x1F.
        for (int n = 1; n <= LOCK_RUN; n++) begin
            step(tokens[0]);
            if (n == 1) begin
                check("lock_tok_de", de, 0);
                check("lock_tok_ctrl", ctrl, 0);
            end
        end
        check("lock_not_yet", locked, 0);
        step(10'h1F5);
        check("lock_at_edge9", locked, 1);
        check("lock_data_de", de, 1);
        check("lock_data_val", dataOut, 8'h1F);
        check("lock_data_ctrl", ctrl, 0);
        step(10'h1F5);
        check("lock_data_val2", dataOut, 8'h1F);

        // Random mix of encoded bytes and tokens while locked.
        exp_ctrl = 2'b00;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                kk = 2'($urandom_range(0, 3));
                step(tokens[kk]);
                exp_ctrl = kk;
                check("rnd_tok_de", de, 0);
            end else begin
                rand_word(w, b);
                step(w);
                check("rnd_de", de, 1);
                check("rnd_data", dataOut, b);
            end
            check("rnd_ctrl", ctrl, exp_ctrl);
        end
        check("rnd_locked", locked, 1);

        // Control hold across data, then a new token.
        step(tokens[2]);
        check("ctl_de0", de, 0);
        check("ctl_10", ctrl, 2'b10);
        for (int n = 0; n < 3; n++) begin
            rand_word(w, b);
            step(w);
            check("ctl_de1", de, 1);
            check("ctl_hold", ctrl, 2'b10);
            check("ctl_data", dataOut, b);
        end
        step(tokens[3]);
        check("ctl_de0b", de, 0);
        check("ctl_11", ctrl, 2'b11);

        // Loss of alignment after LOSS_WINDOW words without a token.
        for (int n = 1; n <= LW; n++) begin
            rand_word(w, b);
            step(w);
            if (n == LW - 1) check("loss_hold", locked, 1);
            if (n == LW)     check("loss_drop", locked, 0);
        end
        seen = 0;
        for (int n = 0; n < SW; n++) begin
            rand_word(w, b);
            step(w);
            if (bitslip) seen = 1;
        end
        check("loss_no_early_slip", seen, 0);
        found = 0;
        for (int n = 0; n < 8 && found == 0; n++) begin
            rand_word(w, b);
            step(w);
            if (bitslip) found = 1;
        end
        check("loss_slip_after_window", found, 1);
        if (found == 1) begin
            resetn = 1'b0;
            #1;
            check_reset_values("slip_reset");
        end
        @(negedge pixelClk);
        do_reset();

        // Token run completes exactly as the search window runs out: lock wins, no slip.
        seen = 0;
        for (int n = 1; n <= SW + 4; n++) begin
            if (n >= SW - LOCK_RUN && n <= SW - 1) begin
                step(tokens[0]);
            end else begin
                rand_word(w, b);
                step(w);
            end
            if (bitslip) seen = 1;
            if (n == SW - 1) check("coinc_not_yet", locked, 0);
            if (n == SW)     check("coinc_locked", locked, 1);
        end
        check("coinc_no_slip", seen, 0);
        check("coinc_still_locked", locked, 1);
        do_reset();

        // Misaligned by 3 bits; the deserializer model rotates the word boundary on each bitslip.
        offset    = 7;
        n_slip    = 0;
        last_slip = 0;
        min_gap   = 1000000;
        cyc       = 0;
        got_lock  = 0;
        for (int c = 0; c < 20000 && got_lock == 0; c++) begin
            step(rot(tokens[0], offset));
            cyc++;
            if (bitslip) begin
                if (n_slip > 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
                last_slip = cyc;
                n_slip++;
                offset = (offset + 1) % 10;
            end
            if (locked) got_lock = 1;
        end
        check("mis_locked", got_lock, 1);
        check("mis_slip_count", n_slip, 3);
        check("mis_slip_gap_ok", (min_gap >= SW + SETTLE) ? 1 : 0, 1);

`ifdef TMDS_DEC_ERRCNT_EN
        do_reset();
        for (int n = 0; n < LOCK_RUN; n++) step(tokens[0]);
        rand_word(w, b);
        step(w);
        check("err_locked", locked, 1);
        check("err_zero", errCount, 0);
        for (int r = 0; r < 3; r++) begin
            step(tokens[1]);
            step(tokens[1]);
            rand_word(w, b);
            step(w);
        end
        check("err_three", errCount, 3);
        step(tokens[0]);
        resetn = 1'b0;
        #1;
        check_reset_values("err_reset");
        @(negedge pixelClk);
        resetn = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
